// File: rtl/mrd_mem_pkt.sv
// Shared types for the mixed-radix DFT memory write-back path: bank/lane counts,
// the per-beat tag carried from read issue to write issue, and the stage FSM states.
package mrd_mem_pkt;

   localparam int wADDR     = 9;
   localparam int NUM_BANKS = 7;
   localparam int NUM_LANES = 5;

   localparam logic [2:0] BANK_IDX_INVALID = 3'd7;

   typedef struct packed {
      logic [NUM_LANES-1:0][2:0]       index;
      logic [NUM_LANES-1:0][wADDR-1:0] addr;
   } wr_tag_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } wr_state_e;

endpackage

// File: rtl/mrd_wr_tag_fifo.sv
// Synchronous tag FIFO with registered full/empty and a synchronous flush.
// Push while full and pop while empty are ignored; flush overrides both.
module mrd_wr_tag_fifo
   import mrd_mem_pkt::*;
#(
   parameter int DEPTH = 16
) (
   input  logic    clk,
   input  logic    rst_n,
   input  logic    flush,
   input  logic    push,
   input  logic    pop,
   input  wr_tag_t push_data,
   output wr_tag_t pop_data,
   output logic    full,
   output logic    empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          full_q, full_d;
   logic          empty_q, empty_d;
   logic          do_push, do_pop;
   wr_tag_t       mem_q [DEPTH];

   assign do_push = push & ~full_q & ~flush;
   assign do_pop  = pop & ~empty_q & ~flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         // Pointers wrap naturally because DEPTH is a power of two.
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
      full_d  = (cnt_d == (AW+1)'(DEPTH));
      empty_d = (cnt_d == '0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

   assign pop_data = mem_q[rd_ptr_q];
   assign full     = full_q;
   assign empty    = empty_q;

endmodule

// File: rtl/mrd_rdx_wr_back.sv
// Butterfly write-back: pairs result beats with buffered read tags and scatters lanes
// into the seven RAM banks. MRD_WR_COLLISION_CHK_EN enables the sticky bank-collision flag.
module mrd_rdx_wr_back
   import mrd_mem_pkt::*;
#(
   parameter int W_ADDR    = 9,
   parameter int W_DATA    = 18,
   parameter int TAG_DEPTH = 16
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 stage_start,
   input  logic [11:0]                          expected_cnt,
   input  logic                                 tag_valid,
   input  logic [NUM_LANES-1:0][2:0]            tag_index,
   input  logic [NUM_LANES-1:0][W_ADDR-1:0]     tag_addr,
   input  logic                                 rdx_valid,
   input  logic [NUM_LANES-1:0][W_DATA-1:0]     rdx_real,
   input  logic [NUM_LANES-1:0][W_DATA-1:0]     rdx_imag,
   output logic [NUM_BANKS-1:0]                 wren,
   output logic [NUM_BANKS-1:0][W_ADDR-1:0]     wraddr,
   output logic [NUM_BANKS-1:0][W_DATA-1:0]     wrdata_real,
   output logic [NUM_BANKS-1:0][W_DATA-1:0]     wrdata_imag,
   output logic                                 wr_end,
   output logic                                 busy,
   output logic                                 err_align,
   output logic                                 err_ovf,
   output logic                                 err_collision
);

   wr_state_e state_q, state_d;
   logic [11:0] cnt_q, cnt_d;
   logic [11:0] exp_q, exp_d;
   logic        beat_q, beat_d;
   logic        err_align_q, err_align_d;
   logic        err_ovf_q, err_ovf_d;

   logic [NUM_BANKS-1:0]             wren_q, wren_d;
   logic [NUM_BANKS-1:0][W_ADDR-1:0] wraddr_q, wraddr_d;
   logic [NUM_BANKS-1:0][W_DATA-1:0] wr_re_q, wr_re_d;
   logic [NUM_BANKS-1:0][W_DATA-1:0] wr_im_q, wr_im_d;

   logic    flush, push, pop, full, empty;
   wr_tag_t push_tag, head;

   assign push_tag.index = tag_index;
   assign push_tag.addr  = tag_addr;

   mrd_wr_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .push     (push),
      .pop      (pop),
      .push_data(push_tag),
      .pop_data (head),
      .full     (full),
      .empty    (empty)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      exp_d       = exp_q;
      beat_d      = 1'b0;
      err_align_d = err_align_q;
      err_ovf_d   = err_ovf_q;
      flush       = 1'b0;
      push        = 1'b0;
      pop         = 1'b0;
      wren_d      = '0;
      wraddr_d    = '0;
      wr_re_d     = '0;
      wr_im_d     = '0;
      if (stage_start) begin
         state_d = ST_RUN;
         flush   = 1'b1;
         cnt_d   = '0;
         exp_d   = expected_cnt;
      end else begin
         case (state_q)
            ST_IDLE: ;
            ST_DONE: state_d = ST_IDLE;
            ST_RUN: begin
               // The final beat's write is on the bus this cycle; wr_end follows.
               if (beat_q && (cnt_q == exp_q)) state_d = ST_DONE;
               if (tag_valid) begin
                  if (full) err_ovf_d = 1'b1;
                  else      push      = 1'b1;
               end
               if (rdx_valid) begin
                  if (empty) begin
                     err_align_d = 1'b1;
                  end else if (cnt_q != exp_q) begin
                     pop    = 1'b1;
                     beat_d = 1'b1;
                     cnt_d  = cnt_q + 12'd1;
                     // Descending lane order lets the lowest lane overwrite on a collision.
                     for (int k = NUM_LANES-1; k >= 0; k--) begin
                        if (head.index[k] != BANK_IDX_INVALID) begin
                           wren_d[head.index[k]]   = 1'b1;
                           wraddr_d[head.index[k]] = head.addr[k];
                           wr_re_d[head.index[k]]  = rdx_real[k];
                           wr_im_d[head.index[k]]  = rdx_imag[k];
                        end
                     end
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         exp_q       <= '0;
         beat_q      <= 1'b0;
         err_align_q <= 1'b0;
         err_ovf_q   <= 1'b0;
         wren_q      <= '0;
         wraddr_q    <= '0;
         wr_re_q     <= '0;
         wr_im_q     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         exp_q       <= exp_d;
         beat_q      <= beat_d;
         err_align_q <= err_align_d;
         err_ovf_q   <= err_ovf_d;
         wren_q      <= wren_d;
         wraddr_q    <= wraddr_d;
         wr_re_q     <= wr_re_d;
         wr_im_q     <= wr_im_d;
      end
   end

`ifdef MRD_WR_COLLISION_CHK_EN
   logic coll_hit;
   logic err_coll_q, err_coll_d;

   always_comb begin
      coll_hit = 1'b0;
      for (int k = 0; k < NUM_LANES; k++) begin
         for (int j = k + 1; j < NUM_LANES; j++) begin
            if ((head.index[k] != BANK_IDX_INVALID) && (head.index[k] == head.index[j]))
               coll_hit = 1'b1;
         end
      end
      err_coll_d = err_coll_q | (pop & coll_hit);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) err_coll_q <= 1'b0;
      else        err_coll_q <= err_coll_d;
   end

   assign err_collision = err_coll_q;
`else
   assign err_collision = 1'b0;
`endif

   assign wren        = wren_q;
   assign wraddr      = wraddr_q;
   assign wrdata_real = wr_re_q;
   assign wrdata_imag = wr_im_q;
   assign busy        = (state_q == ST_RUN);
   assign wr_end      = (state_q == ST_DONE);
   assign err_align   = err_align_q;
   assign err_ovf     = err_ovf_q;

endmodule

// File: doc/mrd_rdx_wr_back.md
Name: mrd_rdx_wr_back

Overview:
Write-back stage downstream of the radix-2/3/4/5 butterfly in the mixed-radix DFT memory subsystem. Captures the bank index/address tags issued with each read beat and buffers them across the butterfly latency. Pairs each butterfly result beat with its tags and scatters the five result lanes into the seven single-port RAM banks. Reports stage completion via a wr_end pulse.

Parameters:
W_ADDR, 9, bank address width; equals mrd_mem_pkt::wADDR
W_DATA, 18, per-component sample width
TAG_DEPTH, 16, tag FIFO depth in entries, power of 2, minimum 2

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
stage_start  in  1  one-cycle pulse: a new stage begins
expected_cnt  in  12  butterfly beats in this stage; sampled on stage_start; value 0 is illegal
tag_valid  in  1  read beat issued; tags valid
tag_index  in  5x3  per-lane bank index; 7 = lane unused
tag_addr  in  5xW_ADDR  per-lane bank address
rdx_valid  in  1  butterfly result beat valid
rdx_real  in  5xW_DATA  result lanes, real part
rdx_imag  in  5xW_DATA  result lanes, imaginary part
wren  out  7  per-bank write enable
wraddr  out  7xW_ADDR  per-bank write address
wrdata_real  out  7xW_DATA  per-bank write data, real part
wrdata_imag  out  7xW_DATA  per-bank write data, imaginary part
wr_end  out  1  one-cycle pulse after the last write of the stage
busy  out  1  high in RUN state
err_align  out  1  sticky: rdx_valid seen with tag FIFO empty
err_ovf  out  1  sticky: tag_valid seen with tag FIFO full
err_collision  out  1  sticky: two lanes of one beat target the same bank

Behaviour:
- Reset: all outputs 0, FIFO empty, beat counter 0, FSM in IDLE. Reset mid-stage discards all tags with no write and no wr_end.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on stage_start. On entry: FIFO flushed, counter cleared, expected_cnt latched.
  - RUN -> DONE in the cycle the write beat with counter == latched expected_cnt is issued.
  - DONE -> IDLE unconditionally after one cycle. wr_end = 1 only in DONE; busy = 1 only in RUN.
  - stage_start in RUN or DONE restarts: FIFO flushed, counter cleared, next state RUN, no wr_end for the aborted stage. Sticky errors are not cleared by stage_start; only rst_n clears them.
- Tag capture: in RUN, tag_valid pushes {tag_index, tag_addr} into the FIFO. A push while the FIFO is full is dropped and sets err_ovf. Tags arriving in IDLE or DONE are ignored.
- Write issue: in RUN, rdx_valid pops one entry.
  - Same cycle as pop plus empty FIFO: no push bypass. The pop fails, err_align is set, and nothing is written.
  - A simultaneous push and pop on a non-empty FIFO are both performed.
- Lane scatter: for each lane k with index i != 7, the registered outputs drive wren[i] = 1, wraddr[i] = tag_addr[k], and wrdata[i] = rdx lane k.
  - Banks not targeted: wren 0, wraddr and wrdata 0.
  - Latency: rdx_valid at cycle n -> wren at cycle n+1.
  - Counter increments on every successful pop.
- Collision: if two or more lanes target one bank, the lowest lane wins.
- Counter is 12-bit and never wraps: expected_cnt <= 4095.
- Beats after DONE are ignored until the next stage_start.

Optional Feature:
MRD_WR_COLLISION_CHK_EN
- Defined: err_collision is driven as specified. A beat that collides still issues the winning-lane writes.
- Undefined: the compare logic is omitted and err_collision is tied 0. The lowest-lane-wins priority still applies.

Decomposition:
- mrd_mem_pkt holds:
  - wADDR
  - NUM_BANKS = 7
  - NUM_LANES = 5
  - BANK_IDX_INVALID = 3'd7
  - the tag struct typedef {index[5], addr[5]}
  - the FSM state enum
- Sub-module mrd_wr_tag_fifo: a synchronous FIFO with registered full/empty and synchronous flush, storing the tag struct at TAG_DEPTH entries.

Test Plan:
- Normal stage, expected_cnt=3: stage_start, then 3 tags with lanes 0..4 -> banks {0,1,2,3,4}, addrs {5,6,7,8,9}; butterfly beats delayed 8 cycles -> each beat writes wren=7'b0011111 with matching addr/data one cycle after rdx_valid; wr_end pulses once, exactly 1 cycle after the third write; busy drops with wr_end.
- Radix-3 beat, index {6,0,3,7,7}: wren=7'b1001001, banks 4/5 silent, lanes 3/4 discarded.
- rdx_valid with empty FIFO in RUN: err_align=1 sticky, wren=0, counter unchanged.
- 17 tags pushed, no pops, TAG_DEPTH=16: err_ovf=1; 16 subsequent beats write the first 16 tags in order.
- Collision, index {2,2,7,7,7} with macro defined: only lane 0 written to bank 2, err_collision=1; macro undefined: same write, err_collision stays 0.
- stage_start re-issued after 1 of 4 beats, then rst_n low mid-stage: no wr_end for the aborted stage, all outputs 0, errors cleared after reset.
